debug_halt_ctl: RTL

- Sits directly downstream of the debug-port watcher. Consumes DEBUG_AT_BKP / DEBUG_IN_WATCH together with the CPU phase strobes and host debug requests.
- Decides when the CPU halts, always on an instruction boundary after COMMIT. Drives the halt line back to the phase sequencer.
- Latches halt cause, the fetch address of the last committed instruction, and a saturating hit counter for the host debug port.

---
 rtl/debug_halt_ctl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/debug_halt_ctl.sv
// Debug halt controller: halts the CPU on an instruction boundary after COMMIT
// and latches halt cause, halt address and a saturating bkp/watch hit counter.
module debug_halt_ctl #(
    parameter int unsigned HIT_W        = 8,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FETCH,
    input  logic             DECODE,
    input  logic             EXECUTE,
    input  logic             COMMIT,
    input  logic [15:0]      ADDR,
    input  logic             DEBUG_AT_BKP,
    input  logic             DEBUG_IN_WATCH,
    input  logic             DEBUG_HALT_REQ,
    input  logic             DEBUG_RUN_REQ,
    input  logic             DEBUG_STEP_REQ,
    input  logic             DEBUG_CLR_REQ,
    output logic             DEBUG_HALT,
    output logic             DEBUG_HALTED,
    output logic [3:0]       DEBUG_CAUSE,
    output logic [15:0]      DEBUG_HALT_ADDR,
    output logic [HIT_W-1:0] DEBUG_HIT_COUNT
);

    typedef enum logic [1:0] {
        S_RUN,
        S_PEND,
        S_HALTED,
        S_STEP
    } state_t;

    localparam logic [3:0] CAUSE_STEP = 4'b1000;
    localparam logic [3:0] CAUSE_HOST = 4'b0100;

    state_t            state, state_nxt;
    logic [15:0]       fetch_addr;
    logic [3:0]        pend_cause, pend_nxt;
    logic [3:0]        cause, cause_nxt;
    logic [15:0]       halt_addr, halt_addr_nxt;
    logic [HIT_W-1:0]  hit_count, hit_count_nxt;
    logic [3:0]        ev;
    logic              enter;
    logic [3:0]        entry_cause;

    assign ev = {1'b0, DEBUG_HALT_REQ, DEBUG_IN_WATCH, DEBUG_AT_BKP};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= RESET_HALTED ? S_HALTED : S_RUN;
            cause      <= RESET_HALTED ? CAUSE_HOST : 4'b0000;
            pend_cause <= '0;
            fetch_addr <= '0;
            halt_addr  <= '0;
            hit_count  <= '0;
        end else begin
            state      <= state_nxt;
            cause      <= cause_nxt;
            pend_cause <= pend_nxt;
            halt_addr  <= halt_addr_nxt;
            hit_count  <= hit_count_nxt;
            if (FETCH) begin
                fetch_addr <= ADDR;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        pend_nxt      = pend_cause;
        cause_nxt     = cause;
        halt_addr_nxt = halt_addr;
        hit_count_nxt = hit_count;
        enter         = 1'b0;
        entry_cause   = '0;

        if (DEBUG_CLR_REQ) begin
            cause_nxt     = '0;
            hit_count_nxt = '0;
        end

        case (state)
            S_RUN: begin
                if (COMMIT && ((ev | pend_cause) != 4'b0000)) begin
                    enter       = 1'b1;
                    entry_cause = ev | pend_cause;
                end else if (ev != 4'b0000) begin
                    state_nxt = S_PEND;
                    pend_nxt  = pend_cause | ev;
                end
            end
            S_PEND: begin
                if (COMMIT) begin
                    enter       = 1'b1;
                    entry_cause = ev | pend_cause;
                end else begin
                    pend_nxt = pend_cause | ev;
                end
            end
            S_HALTED: begin
                if (DEBUG_STEP_REQ) begin
                    state_nxt = S_STEP;
                    cause_nxt = '0;
                end else if (DEBUG_RUN_REQ) begin
                    state_nxt = S_RUN;
                    cause_nxt = '0;
                end
            end
            S_STEP: begin
                if (COMMIT) begin
                    enter       = 1'b1;
                    entry_cause = ev | pend_cause | CAUSE_STEP;
                end else begin
                    pend_nxt = pend_cause | ev;
                end
            end
            default: state_nxt = S_RUN;
        endcase

        // Halt entry is applied on top of a coincident clear, so the new cause survives.
        if (enter) begin
            state_nxt     = S_HALTED;
            cause_nxt     = entry_cause;
            halt_addr_nxt = fetch_addr;
            pend_nxt      = '0;
            if ((entry_cause[1:0] != 2'b00) && (hit_count_nxt != '1)) begin
                hit_count_nxt = hit_count_nxt + HIT_W'(1);
            end
        end
    end

    assign DEBUG_HALT      = (state == S_HALTED);
    assign DEBUG_HALTED    = (state == S_HALTED);
    assign DEBUG_CAUSE     = cause;
    assign DEBUG_HALT_ADDR = halt_addr;
    assign DEBUG_HIT_COUNT = hit_count;

endmodule
